// File: rtl/fetch_npc_unit_pkg.sv
// Shared pipeline constants for the fetch stage: branch-type codes,
// reset PC and legal instruction-memory window.
package fetch_npc_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JR   = 3'd4
  } br_type_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the fetch stage (purely combinational).
// In: f_pc, fd_pc, br_type, cmp_eq, d_imm16, d_index26, d_jr_target.
// Out: npc (next fetch address), d_taken (redirect this cycle).
module npc_calc
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] fd_pc,
  input  logic [2:0]  br_type,
  input  logic        cmp_eq,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_jr_target,
  output logic [31:0] npc,
  output logic        d_taken
);

  logic [31:0] w_seq;
  logic [31:0] w_fd_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_tgt;

  assign w_seq    = f_pc + 32'd4;
  assign w_fd_pc4 = fd_pc + 32'd4;
  assign w_br_tgt = w_fd_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign w_j_tgt  = {w_fd_pc4[31:28], d_index26, 2'b00};

  // Unknown encodings fall to the default arm and behave as NONE.
  always_comb begin
    d_taken = 1'b0;
    w_tgt   = w_br_tgt;
    case (br_type)
      BR_BEQ: d_taken = cmp_eq;
      BR_BNE: d_taken = ~cmp_eq;
      BR_J: begin
        d_taken = 1'b1;
        w_tgt   = w_j_tgt;
      end
      BR_JR: begin
        d_taken = 1'b1;
        w_tgt   = d_jr_target;
      end
      default: d_taken = 1'b0;
    endcase
  end

  assign npc = d_taken ? w_tgt : w_seq;

endmodule

// File: rtl/fetch_npc_unit.sv
// F-stage front end: PC register, F/D pipeline register, next-PC mux.
// In: clk, reset (async, high), stall, br_type, cmp_eq, d_imm16,
//     d_index26, d_jr_target, im_rdata.
// Out: f_pc, fd_instr, fd_pc, fd_exc, d_taken.
// Optional fetch-address check enabled by macro PC_ALIGN_CHECK_EN.
module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  br_type,
  input  logic        cmp_eq,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_jr_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_exc,
  output logic        d_taken
);

  logic [31:0] r_pc;
  logic [31:0] r_fd_instr;
  logic [31:0] r_fd_pc;
  logic        r_fd_exc;
  logic [31:0] w_npc;
  logic        w_bad;
  logic [31:0] w_instr;

  npc_calc u_npc_calc (
    .f_pc        (r_pc),
    .fd_pc       (r_fd_pc),
    .br_type     (br_type),
    .cmp_eq      (cmp_eq),
    .d_imm16     (d_imm16),
    .d_index26   (d_index26),
    .d_jr_target (d_jr_target),
    .npc         (w_npc),
    .d_taken     (d_taken)
  );

`ifdef PC_ALIGN_CHECK_EN
  // Faulting fetches enter D as a nop tagged with the exception flag.
  assign w_bad = (r_pc[1:0] != 2'b00) ||
                 (r_pc < IM_BASE) ||
                 (r_pc > IM_TOP);
  assign w_instr = w_bad ? 32'd0 : im_rdata;
`else
  assign w_bad   = 1'b0;
  assign w_instr = im_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_fd_instr <= 32'd0;
      r_fd_pc    <= 32'd0;
      r_fd_exc   <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_npc;
      r_fd_instr <= w_instr;
      r_fd_pc    <= r_pc;
      r_fd_exc   <= w_bad;
    end
  end

  assign f_pc     = r_pc;
  assign fd_instr = r_fd_instr;
  assign fd_pc    = r_fd_pc;
  assign fd_exc   = r_fd_exc;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed bench for fetch_npc_unit with an expected-state scoreboard.
module tb_fetch_npc_unit;
  import fetch_npc_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  br_type;
  logic        cmp_eq;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_jr_target;
  logic [31:0] im_rdata;
  logic [31:0] f_pc;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fd_exc;
  logic        d_taken;

  int total;
  int bad;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] fdpc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t q[$];

  fetch_npc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_type     (br_type),
    .cmp_eq      (cmp_eq),
    .d_imm16     (d_imm16),
    .d_index26   (d_index26),
    .d_jr_target (d_jr_target),
    .im_rdata    (im_rdata),
    .f_pc        (f_pc),
    .fd_instr    (fd_instr),
    .fd_pc       (fd_pc),
    .fd_exc      (fd_exc),
    .d_taken     (d_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic fault(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  assign im_rdata = imw(f_pc);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the state expected after the next edge, clock, then pop/compare.
  task automatic step(input string tag, input logic [31:0] efpc,
                      input logic [31:0] efdpc);
    exp_t e;
    exp_t g;
    e.fpc   = efpc;
    e.fdpc  = efdpc;
    e.exc   = fault(efdpc);
    e.instr = e.exc ? 32'd0 : imw(efdpc);
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk({tag, ".f_pc"}, f_pc, g.fpc);
    chk({tag, ".fd_pc"}, fd_pc, g.fdpc);
    chk({tag, ".fd_instr"}, fd_instr, g.instr);
    chk({tag, ".fd_exc"}, {31'd0, fd_exc}, {31'd0, g.exc});
  endtask

  // Held state: same checks, but the expected word is the one already in F/D.
  task automatic hold(input string tag, input logic [31:0] efpc,
                      input logic [31:0] efdpc, input logic [31:0] einstr);
    @(posedge clk);
    #1;
    chk({tag, ".f_pc"}, f_pc, efpc);
    chk({tag, ".fd_pc"}, fd_pc, efdpc);
    chk({tag, ".fd_instr"}, fd_instr, einstr);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    stall = 1'b0;
    br_type = BR_NONE;
    cmp_eq = 1'b0;
    d_imm16 = 16'd0;
    d_index26 = 26'd0;
    d_jr_target = 32'd0;

    #2;
    chk("rst.f_pc", f_pc, 32'h3000);
    chk("rst.fd_instr", fd_instr, 32'd0);
    chk("rst.fd_pc", fd_pc, 32'd0);
    chk("rst.fd_exc", {31'd0, fd_exc}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    step("seq1", 32'h3004, 32'h3000);
    step("seq2", 32'h3008, 32'h3004);
    step("seq3", 32'h300C, 32'h3008);

    br_type = BR_BEQ;
    cmp_eq = 1'b1;
    d_imm16 = 16'hFFFE;
    #1;
    chk("beq.taken", {31'd0, d_taken}, 32'd1);
    step("beq", 32'h3004, 32'h300C);

    br_type = BR_BNE;
    cmp_eq = 1'b1;
    d_imm16 = 16'h0010;
    #1;
    chk("bne_nt.taken", {31'd0, d_taken}, 32'd0);
    step("bne_nt", 32'h3008, 32'h3004);

    cmp_eq = 1'b0;
    #1;
    chk("bne_t.taken", {31'd0, d_taken}, 32'd1);
    step("bne_t", 32'h3048, 32'h3008);

    br_type = BR_NONE;
    step("seq4", 32'h304C, 32'h3048);

    br_type = BR_JR;
    d_jr_target = 32'h0000_3100;
    stall = 1'b1;
    #1;
    chk("jr_stall.taken", {31'd0, d_taken}, 32'd1);
    hold("stall1", 32'h304C, 32'h3048, imw(32'h3048));
    hold("stall2", 32'h304C, 32'h3048, imw(32'h3048));
    stall = 1'b0;
    step("jr", 32'h3100, 32'h304C);

    br_type = BR_NONE;
    step("seq5", 32'h3104, 32'h3100);

    br_type = BR_J;
    d_index26 = 26'h0000C40;
    step("j", 32'h3100, 32'h3104);

    br_type = 3'd7;
    cmp_eq = 1'b1;
    #1;
    chk("unk.taken", {31'd0, d_taken}, 32'd0);
    step("unk", 32'h3104, 32'h3100);

    br_type = BR_J;
    #3;
    reset = 1'b1;
    #1;
    chk("mrst.f_pc", f_pc, 32'h3000);
    chk("mrst.fd_instr", fd_instr, 32'd0);
    chk("mrst.fd_pc", fd_pc, 32'd0);
    stall = 1'b1;
    @(posedge clk);
    #1;
    chk("rstpri.f_pc", f_pc, 32'h3000);
    chk("rstpri.fd_pc", fd_pc, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    br_type = BR_NONE;
    step("post_rst", 32'h3004, 32'h3000);

    br_type = BR_JR;
    d_jr_target = 32'h0000_3102;
    step("jr_mis", 32'h3102, 32'h3004);
    br_type = BR_NONE;
    step("f_mis", 32'h3106, 32'h3102);
    br_type = BR_JR;
    d_jr_target = 32'h0000_7000;
    step("jr_hi", 32'h7000, 32'h3106);
    br_type = BR_NONE;
    step("f_hi", 32'h7004, 32'h7000);
    br_type = BR_JR;
    d_jr_target = 32'h0000_6FFC;
    step("jr_top", 32'h6FFC, 32'h7004);
    br_type = BR_NONE;
    step("f_top", 32'h7000, 32'h6FFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
